count_status_checker: RTL and testbench

Receiver-side monitor for the count_status sequencer's `_i`/`_index` output pair. It samples the pair on qualified cycles and acquires lock on the four-step cyclic sequence. Once locked, it flags every deviation. It sits beside the sequencer in test/diagnostic builds and gives a lock indication plus a saturating error count for status readout.

---
 rtl/count_status_pkg.sv | 35 +++
 rtl/count_status_checker_sat_counter.sv | 36 +++
 rtl/count_status_checker.sv | 132 +++++++++++++
 tb/tb_count_status_checker.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/count_status_pkg.sv
// Shared types and constants for the count_status sequencer output checker.
package count_status_pkg;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_e;

  localparam int unsigned STATE_MOD   = 4;
  localparam logic [3:0]  IDX_POS0    = 4'd0;
  localparam logic [3:0]  IDX_POS1    = 4'd5;
  localparam logic [3:0]  IDX_POS2    = 4'd12;
  localparam logic [3:0]  IDX_POS3    = 4'd7;
  localparam logic [3:0]  START_I     = 4'd2;
  localparam logic [3:0]  START_INDEX = 4'd1;

  function automatic logic [3:0] exp_index(input logic [1:0] pos);
    logic [3:0] idx;
    case (pos)
      2'd0:    idx = IDX_POS0;
      2'd1:    idx = IDX_POS1;
      2'd2:    idx = IDX_POS2;
      2'd3:    idx = IDX_POS3;
      default: idx = IDX_POS0;
    endcase
    return idx;
  endfunction

  // Two-bit wrap gives the mod-4 successor directly.
  function automatic logic [1:0] next_pos(input logic [1:0] pos);
    return pos + 2'd1;
  endfunction

endpackage

// File: rtl/count_status_checker_sat_counter.sv
// Generic saturating up-counter; clear has priority over increment.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/count_status_checker.sv
// Lock-acquiring monitor for the count_status (_i, _index) pair with a
// saturating error count of deviations seen while locked.
module count_status_checker
  import count_status_pkg::*;
#(
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [3:0]       in_i,
  input  logic [3:0]       in_index,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_cnt,
  output logic [1:0]       exp_pos
);

  localparam logic [3:0] LOCK_RUN = 4'(LOCK_COUNT);

  state_e     state_q, state_d;
  logic [3:0] run_q, run_d;
  logic [1:0] exp_pos_q, exp_pos_d;
  logic       err_pulse_q, err_pulse_d;
  logic       legal_s, match_s;
  logic [3:0] run_inc_s;

  // The start pair only counts as legal while searching; TRACK/LOCKED use match_s.
  assign legal_s = ((in_i[3:2] == 2'b00) && (in_index == exp_index(in_i[1:0]))) ||
                   ((in_i == START_I) && (in_index == START_INDEX));
  assign match_s = (in_i == {2'b00, exp_pos_q}) && (in_index == exp_index(exp_pos_q));
  assign run_inc_s = run_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEARCH;
      run_q       <= 4'd0;
      exp_pos_q   <= 2'd0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      exp_pos_q   <= exp_pos_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (in_valid) begin
      case (state_q)
        SEARCH: begin
          if (legal_s) begin
            state_d = (LOCK_RUN == 4'd1) ? LOCKED : TRACK;
          end else begin
            state_d = SEARCH;
          end
        end
        TRACK: begin
          if (!match_s) begin
            state_d = SEARCH;
          end else if (run_inc_s >= LOCK_RUN) begin
            state_d = LOCKED;
          end else begin
            state_d = TRACK;
          end
        end
        LOCKED: begin
          state_d = match_s ? LOCKED : SEARCH;
        end
        default: state_d = SEARCH;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // A mismatching sample is consumed: it never seeds the next acquisition.
  always_comb begin
    run_d       = run_q;
    exp_pos_d   = exp_pos_q;
    err_pulse_d = 1'b0;
    if (in_valid) begin
      case (state_q)
        SEARCH: begin
          if (legal_s) begin
            run_d     = 4'd1;
            exp_pos_d = next_pos(in_i[1:0]);
          end else begin
            run_d = 4'd0;
          end
        end
        TRACK: begin
          if (match_s) begin
            run_d     = run_inc_s;
            exp_pos_d = next_pos(exp_pos_q);
          end else begin
            run_d = 4'd0;
          end
        end
        LOCKED: begin
          if (match_s) begin
            exp_pos_d = next_pos(exp_pos_q);
          end else begin
            run_d       = 4'd0;
            err_pulse_d = 1'b1;
          end
        end
        default: begin
          run_d = 4'd0;
        end
      endcase
    end else begin
      run_d = run_q;
    end
  end

  sat_counter #(.W(ERR_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (err_pulse_d),
    .cnt   (err_cnt)
  );

  assign locked    = (state_q == LOCKED);
  assign err_pulse = err_pulse_q;
  assign exp_pos   = exp_pos_q;

endmodule

// File: tb/tb_count_status_checker.sv
// Randomised and directed bench for count_status_checker; three parameter
// variants share one stimulus stream and one behavioural model each.
module tb_count_status_checker;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [3:0] in_i;
  logic [3:0] in_index;
  logic       clr;

  logic       locked0, pulse0, locked1, pulse1, locked2, pulse2;
  logic [7:0] cnt0, cnt2;
  logic [1:0] cnt1;
  logic [1:0] exp0, exp1, exp2;

  count_status_checker #(.LOCK_COUNT(4), .ERR_W(8)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_i(in_i), .in_index(in_index),
    .clr(clr), .locked(locked0), .err_pulse(pulse0), .err_cnt(cnt0), .exp_pos(exp0));
  count_status_checker #(.LOCK_COUNT(4), .ERR_W(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_i(in_i), .in_index(in_index),
    .clr(clr), .locked(locked1), .err_pulse(pulse1), .err_cnt(cnt1), .exp_pos(exp1));
  count_status_checker #(.LOCK_COUNT(1), .ERR_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_i(in_i), .in_index(in_index),
    .clr(clr), .locked(locked2), .err_pulse(pulse2), .err_cnt(cnt2), .exp_pos(exp2));

  logic [11:0] obs [3];
  assign obs[0] = {locked0, pulse0, cnt0, exp0};
  assign obs[1] = {locked1, pulse1, 6'd0, cnt1, exp1};
  assign obs[2] = {locked2, pulse2, cnt2, exp2};

  int checks = 0;
  int fails  = 0;

  // Behavioural model: locked flag, length of current legal run, expected position.
  int tbl [4]  = '{0, 5, 12, 7};
  int lc  [3]  = '{4, 4, 1};
  int mx  [3]  = '{255, 3, 255};
  bit m_locked [3];
  bit m_pulse  [3];
  int m_run    [3];
  int m_exp    [3];
  int m_cnt    [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] mvec(int k);
    return {m_locked[k], m_pulse[k], 8'(m_cnt[k]), 2'(m_exp[k])};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_locked[k] = 1'b0; m_pulse[k] = 1'b0;
      m_run[k] = 0; m_exp[k] = 0; m_cnt[k] = 0;
    end
  endtask

  task automatic model_step(input bit v, input int i, input int idx, input bit c);
    bit legal, match, err;
    for (int k = 0; k < 3; k++) begin
      err = 1'b0;
      if (v) begin
        legal = ((i < 4) && (idx == tbl[i % 4])) || (i == 2 && idx == 1);
        match = (i == m_exp[k]) && (idx == tbl[m_exp[k]]);
        if (m_locked[k]) begin
          if (match) m_exp[k] = (m_exp[k] + 1) % 4;
          else begin err = 1'b1; m_locked[k] = 1'b0; m_run[k] = 0; end
        end else if (m_run[k] > 0) begin
          if (match) begin
            m_run[k]++; m_exp[k] = (m_exp[k] + 1) % 4;
            if (m_run[k] >= lc[k]) m_locked[k] = 1'b1;
          end else m_run[k] = 0;
        end else if (legal) begin
          m_run[k] = 1; m_exp[k] = (i + 1) % 4;
          if (lc[k] == 1) m_locked[k] = 1'b1;
        end else m_run[k] = 0;
      end
      m_pulse[k] = err;
      if (c) m_cnt[k] = 0;
      else if (err && m_cnt[k] < mx[k]) m_cnt[k]++;
    end
  endtask

  task automatic drive(input bit v, input int i, input int idx, input bit c);
    @(negedge clk);
    in_valid = v; in_i = 4'(i); in_index = 4'(idx); clr = c;
    @(posedge clk);
    model_step(v, i, idx, c);
    #1;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b0; clr = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_i = 4'd0; in_index = 4'd0; clr = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== 12'h000) begin
        $display("FAIL reset_state[%0d] got=%h want=%h", k, obs[k], 12'h000); fails++;
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_nominal();
    int ps [5][2] = '{'{2,1}, '{3,7}, '{0,0}, '{1,5}, '{2,12}};
    for (int s = 0; s < 5; s++) begin
      drive(1'b1, ps[s][0], ps[s][1], 1'b0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== mvec(k)) begin
          $display("FAIL nominal[%0d] step%0d got=%h want=%h", k, s, obs[k], mvec(k)); fails++;
        end
      end
    end
    checks++;
    if ({locked0, cnt0, exp0} !== {1'b1, 8'd0, 2'd3}) begin
      $display("FAIL nominal_lock got=%h want=%h", {locked0, cnt0, exp0}, {1'b1, 8'd0, 2'd3}); fails++;
    end
  endtask

  task automatic test_corrupt_locked();
    int ps [5][2] = '{'{3,6}, '{0,0}, '{1,5}, '{2,12}, '{3,7}};
    for (int s = 0; s < 5; s++) begin
      drive(1'b1, ps[s][0], ps[s][1], 1'b0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== mvec(k)) begin
          $display("FAIL corrupt[%0d] step%0d got=%h want=%h", k, s, obs[k], mvec(k)); fails++;
        end
      end
      if (s == 0) begin
        checks++;
        if ({pulse0, locked0, cnt0} !== {1'b1, 1'b0, 8'd1}) begin
          $display("FAIL corrupt_err got=%h want=%h", {pulse0, locked0, cnt0}, {1'b1, 1'b0, 8'd1}); fails++;
        end
      end
    end
    checks++;
    if ({pulse0, locked0} !== 2'b01) begin
      $display("FAIL corrupt_relock got=%b want=%b", {pulse0, locked0}, 2'b01); fails++;
    end
  endtask

  task automatic test_track_mismatch();
    int ps [4][2] = '{'{2,1}, '{3,7}, '{1,5}, '{0,0}};
    apply_reset();
    for (int s = 0; s < 4; s++) begin
      drive(1'b1, ps[s][0], ps[s][1], 1'b0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== mvec(k)) begin
          $display("FAIL track_mm[%0d] step%0d got=%h want=%h", k, s, obs[k], mvec(k)); fails++;
        end
      end
    end
    checks++;
    if ({locked0, cnt0, exp0} !== {1'b0, 8'd0, 2'd1}) begin
      $display("FAIL track_mm_u0 got=%h want=%h", {locked0, cnt0, exp0}, {1'b0, 8'd0, 2'd1}); fails++;
    end
  endtask

  task automatic test_valid_gaps();
    int ps [8][3] = '{'{1,1,5}, '{1,2,12}, '{1,3,7}, '{0,9,9}, '{0,2,1}, '{0,15,0},
                      '{1,0,0}, '{1,1,5}};
    for (int s = 0; s < 8; s++) begin
      drive(ps[s][0] != 0, ps[s][1], ps[s][2], 1'b0);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== mvec(k)) begin
          $display("FAIL gaps[%0d] step%0d got=%h want=%h", k, s, obs[k], mvec(k)); fails++;
        end
      end
    end
    checks++;
    if ({locked0, pulse0, exp0} !== {1'b1, 1'b0, 2'd2}) begin
      $display("FAIL gaps_u0 got=%h want=%h", {locked0, pulse0, exp0}, {1'b1, 1'b0, 2'd2}); fails++;
    end
  endtask

  task automatic test_saturation();
    int ps [5][2] = '{'{2,1}, '{3,7}, '{0,0}, '{1,5}, '{3,6}};
    apply_reset();
    for (int r = 0; r < 6; r++) begin
      for (int s = 0; s < 5; s++) begin
        drive(1'b1, ps[s][0], ps[s][1], (r == 5 && s == 4));
        for (int k = 0; k < 3; k++) begin
          checks++;
          if (obs[k] !== mvec(k)) begin
            $display("FAIL sat[%0d] r%0d s%0d got=%h want=%h", k, r, s, obs[k], mvec(k)); fails++;
          end
        end
      end
      if (r == 4) begin
        checks++;
        if (cnt1 !== 2'd3) begin
          $display("FAIL sat_stick got=%0d want=%0d", cnt1, 3); fails++;
        end
      end
    end
    checks++;
    if ({pulse1, cnt1} !== {1'b1, 2'd0}) begin
      $display("FAIL sat_clr got=%b want=%b", {pulse1, cnt1}, {1'b1, 2'd0}); fails++;
    end
  endtask

  task automatic test_async_reset();
    int ps [4][2] = '{'{2,1}, '{3,7}, '{0,0}, '{1,5}};
    for (int s = 0; s < 4; s++) drive(1'b1, ps[s][0], ps[s][1], 1'b0);
    checks++;
    if (locked0 !== 1'b1) begin
      $display("FAIL async_prelock got=%b want=%b", locked0, 1'b1); fails++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== 12'h000) begin
        $display("FAIL async_rst[%0d] got=%h want=%h", k, obs[k], 12'h000); fails++;
      end
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 2, 1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (obs[k] !== mvec(k)) begin
        $display("FAIL async_start[%0d] got=%h want=%h", k, obs[k], mvec(k)); fails++;
      end
    end
    checks++;
    if (exp0 !== 2'd3) begin
      $display("FAIL async_start_exp got=%0d want=%0d", exp0, 3); fails++;
    end
  endtask

  task automatic test_random();
    int g = 0;
    int r, p, i, idx;
    bit v, c;
    for (int n = 0; n < 600; n++) begin
      v = ($urandom_range(0, 4) != 0);
      c = ($urandom_range(0, 19) == 0);
      r = $urandom_range(0, 9);
      if (r < 6) begin
        i = g; idx = tbl[g];
        if (v) g = (g + 1) % 4;
      end else if (r == 6) begin
        i = 2; idx = 1;
        if (v) g = 3;
      end else if (r == 7) begin
        p = $urandom_range(0, 3); i = p; idx = tbl[p];
        if (v) g = (p + 1) % 4;
      end else begin
        i = $urandom_range(0, 15); idx = $urandom_range(0, 15);
      end
      drive(v, i, idx, c);
      for (int k = 0; k < 3; k++) begin
        checks++;
        if (obs[k] !== mvec(k)) begin
          $display("FAIL random[%0d] n%0d got=%h want=%h", k, n, obs[k], mvec(k)); fails++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_corrupt_locked();
    test_track_mismatch();
    test_valid_gaps();
    test_saturation();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
